// File: rtl/axi_lite_rd_slave_ctrl_if.sv
// AXI4-Lite read address / read data channels shared by the read slave
// controller and whatever masters it.
interface axi_lite_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_rd_slave_ctrl.sv
// AXI4-Lite read slave: decodes one read at a time, fetches it from a local
// register bank with a one-cycle strobe and holds the response until RREADY.
module axi_lite_rd_slave_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 16,
  parameter int PROT_CHECK = 0,
  parameter int ERRCNT_W   = 8,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_lite_rd_if.slave        bus,
  output logic                reg_rd_en,
  output logic [IDX_W-1:0]    reg_rd_addr,
  input  logic [DATA_W-1:0]   reg_rd_data,
  input  logic                reg_rd_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                busy
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One extra bit so the limit never wraps for a full-width address space.
  localparam logic [ADDR_W:0] OFFSET_LIMIT = (ADDR_W+1)'(NUM_REGS * 4);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_en_d;
  logic [IDX_W-1:0]      rd_addr_d;
  logic [ERRCNT_W-1:0]   err_cnt_d;
  logic                  busy_d;

  logic dec_err, align_err, prot_err;
  logic unused_prot;

  assign dec_err     = {1'b0, bus.ARADDR} >= OFFSET_LIMIT;
  assign align_err   = bus.ARADDR[1:0] != 2'b00;
  assign prot_err    = (PROT_CHECK != 0) && !bus.ARPROT[0];
  assign unused_prot = ^bus.ARPROT[2:1];

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_en_d   = 1'b0;
    rd_addr_d = reg_rd_addr;
    err_cnt_d = err_cnt;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          arready_d = 1'b0;
          // Decode errors outrank alignment, which outranks protection.
          if (dec_err || align_err || prot_err) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = dec_err ? RESP_DECERR : RESP_SLVERR;
          end else begin
            state_d   = REQ;
            rd_en_d   = 1'b1;
            rd_addr_d = bus.ARADDR[IDX_W+1:2];
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
        rdata_d  = reg_rd_data;
        rresp_d  = reg_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      RESP: begin
        if (bus.RREADY) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
          if (rresp_q != RESP_OKAY && err_cnt != '1)
            err_cnt_d = err_cnt + ERRCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      err_cnt     <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      reg_rd_en   <= rd_en_d;
      reg_rd_addr <= rd_addr_d;
      err_cnt     <= err_cnt_d;
      busy        <= busy_d;
    end
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_rd_slave_ctrl.sv
// Bench for axi_lite_rd_slave_ctrl: two instances (protection check off/on)
// share one stimulus stream and are compared against a transaction-level model.
module tb_axi_lite_rd_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rready;

  always #5 clk = ~clk;

  axi_lite_rd_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  axi_lite_rd_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  assign bus0.ARVALID = arvalid;
  assign bus0.ARADDR  = araddr;
  assign bus0.ARPROT  = arprot;
  assign bus0.RREADY  = rready;
  assign bus1.ARVALID = arvalid;
  assign bus1.ARADDR  = araddr;
  assign bus1.ARPROT  = arprot;
  assign bus1.RREADY  = rready;

  logic [1:0]       rd_en;
  logic [1:0][3:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_err;
  logic [1:0][7:0]  ecnt_o;
  logic [1:0]       busy_o;
  logic [1:0]       rv, ar;
  logic [1:0][31:0] rdat;
  logic [1:0][1:0]  rrsp;

  assign rv[0]   = bus0.RVALID;
  assign rv[1]   = bus1.RVALID;
  assign ar[0]   = bus0.ARREADY;
  assign ar[1]   = bus1.ARREADY;
  assign rdat[0] = bus0.RDATA;
  assign rdat[1] = bus1.RDATA;
  assign rrsp[0] = bus0.RRESP;
  assign rrsp[1] = bus1.RRESP;

  axi_lite_rd_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .PROT_CHECK(0), .ERRCNT_W(8)) dut0 (
    .ACLK(clk), .ARESETn(rst_n), .bus(bus0),
    .reg_rd_en(rd_en[0]), .reg_rd_addr(rd_addr[0]), .reg_rd_data(rd_data[0]),
    .reg_rd_err(rd_err[0]), .err_cnt(ecnt_o[0]), .busy(busy_o[0])
  );

  axi_lite_rd_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .PROT_CHECK(1), .ERRCNT_W(8)) dut1 (
    .ACLK(clk), .ARESETn(rst_n), .bus(bus1),
    .reg_rd_en(rd_en[1]), .reg_rd_addr(rd_addr[1]), .reg_rd_data(rd_data[1]),
    .reg_rd_err(rd_err[1]), .err_cnt(ecnt_o[1]), .busy(busy_o[1])
  );

  // Register bank: data valid the cycle after the strobe, junk otherwise.
  logic [31:0] regs[16];
  logic        errs[16];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        rd_data[i] <= regs[rd_addr[i]];
        rd_err[i]  <= errs[rd_addr[i]];
      end else begin
        rd_data[i] <= $urandom;
        rd_err[i]  <= 1'($urandom_range(0, 1));
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int ecnt_m[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected response for one read: resp code, data, and edges from AR handshake to RVALID.
  function automatic void model(input logic [31:0] a, input logic [2:0] p, input bit pc,
                                output logic [1:0] r, output logic [31:0] d, output int lat);
    if (a >= 32'd64) begin
      r = 2'b11; d = 32'h0; lat = 1;
    end else if (a[1:0] != 2'b00) begin
      r = 2'b10; d = 32'h0; lat = 1;
    end else if (pc && !p[0]) begin
      r = 2'b10; d = 32'h0; lat = 1;
    end else begin
      r = errs[a / 4] ? 2'b10 : 2'b00;
      d = regs[a / 4];
      lat = 3;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [2:0] p);
    @(negedge clk);
    araddr  = a;
    arprot  = p;
    arvalid = 1'b1;
    @(posedge clk);
  endtask

  // Runs from just after the AR handshake edge until the read has completed.
  task automatic collect(input logic [31:0] a, input logic [2:0] p, input int hold,
                         input bit keep_ar, input logic [31:0] next_a);
    logic [1:0]  er[2];
    logic [31:0] ed[2];
    int          el[2];
    int          lat[2];
    int          nen[2];
    int          left;
    int          done_cyc;
    for (int i = 0; i < 2; i++) begin
      model(a, p, i[0], er[i], ed[i], el[i]);
      lat[i] = 0;
      nen[i] = 0;
    end
    left     = hold;
    done_cyc = 0;
    rready   = (hold == 0);
    for (int cyc = 1; cyc <= hold + 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (keep_ar) araddr = next_a;
        else arvalid = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (rd_en[i]) begin
          nen[i]++;
          check($sformatf("rd_addr%0d", i), rd_addr[i], a[5:2]);
        end
        if (lat[i] == 0 && rv[i]) begin
          lat[i] = cyc;
          check($sformatf("latency%0d a=%0h", i, a), cyc, el[i]);
          check($sformatf("rdata%0d a=%0h", i, a), rdat[i], ed[i]);
          check($sformatf("rresp%0d a=%0h", i, a), rrsp[i], er[i]);
        end else if (lat[i] != 0 && left > 0) begin
          check($sformatf("hold_rvalid%0d", i), rv[i], 1);
          check($sformatf("hold_rdata%0d", i), rdat[i], ed[i]);
          check($sformatf("hold_rresp%0d", i), rrsp[i], er[i]);
          check($sformatf("hold_arready%0d", i), ar[i], 0);
        end
      end
      if (lat[0] != 0 && cyc > lat[0] && left > 0) left--;
      if (lat[0] != 0 && left == 0 && !rready) begin
        rready   = 1'b1;
        done_cyc = cyc + 1;
      end
      if (done_cyc != 0 && cyc == done_cyc) break;
    end
    for (int i = 0; i < 2; i++) begin
      if (er[i] != 2'b00 && ecnt_m[i] < 255) ecnt_m[i]++;
      check($sformatf("rvalid_seen%0d", i), lat[i] != 0, 1);
      check($sformatf("rd_en_pulses%0d", i), nen[i], (el[i] == 3) ? 1 : 0);
      check($sformatf("err_cnt%0d", i), ecnt_o[i], ecnt_m[i]);
      check($sformatf("final_rvalid%0d", i), rv[i], 0);
      check($sformatf("final_arready%0d", i), ar[i], 1);
      check($sformatf("final_busy%0d", i), busy_o[i], 0);
      check($sformatf("final_rdata%0d", i), rdat[i], 0);
      check($sformatf("final_rresp%0d", i), rrsp[i], 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_arready%0d", tag, i), ar[i], 0);
      check($sformatf("%s_rvalid%0d", tag, i), rv[i], 0);
      check($sformatf("%s_rdata%0d", tag, i), rdat[i], 0);
      check($sformatf("%s_rresp%0d", tag, i), rrsp[i], 0);
      check($sformatf("%s_rd_en%0d", tag, i), rd_en[i], 0);
      check($sformatf("%s_err_cnt%0d", tag, i), ecnt_o[i], 0);
      check($sformatf("%s_busy%0d", tag, i), busy_o[i], 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  p;
    int          r;

    for (int i = 0; i < 16; i++) begin
      regs[i] = $urandom;
      errs[i] = 1'b0;
    end
    rst_n   = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    arprot  = '0;
    rready  = 1'b1;
    ecnt_m[0] = 0;
    ecnt_m[1] = 0;

    // Reset values, then ARREADY on the first edge after release.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 2; i++) check($sformatf("reset_rd_addr%0d", i), rd_addr[i], 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("arready_after_release%0d", i), ar[i], 1);

    // Plain register read.
    regs[2] = 32'hDEADBEEF;
    errs[2] = 1'b0;
    issue(32'h08, 3'b001);
    collect(32'h08, 3'b001, 0, 1'b0, 0);

    // Decode error then misalignment.
    issue(32'h40, 3'b001);
    collect(32'h40, 3'b001, 0, 1'b0, 0);
    issue(32'h06, 3'b001);
    collect(32'h06, 3'b001, 0, 1'b0, 0);

    // Register bank error.
    regs[3] = 32'h0000_1234;
    errs[3] = 1'b1;
    issue(32'h0C, 3'b001);
    collect(32'h0C, 3'b001, 0, 1'b0, 0);
    errs[3] = 1'b0;

    // Unprivileged access: only the protection-checking instance rejects it.
    issue(32'h08, 3'b000);
    collect(32'h08, 3'b000, 0, 1'b0, 0);
    issue(32'h08, 3'b001);
    collect(32'h08, 3'b001, 0, 1'b0, 0);

    // Backpressure with a second request waiting on ARVALID.
    regs[5] = 32'hA5A5_0F0F;
    regs[8] = 32'h1357_9BDF;
    issue(32'h14, 3'b001);
    collect(32'h14, 3'b001, 10, 1'b1, 32'h20);
    collect(32'h20, 3'b001, 0, 1'b0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] = $urandom;
        errs[i] = ($urandom_range(0, 3) == 0);
      end
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 15)) * 4;
      else if (r < 8) a = 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'($urandom_range(64, 400));
      else            a = $urandom | 32'h8000_0000;
      p = 3'($urandom_range(0, 7));
      issue(a, p);
      collect(a, p, 0, 1'b0, 0);
    end
    for (int i = 0; i < 16; i++) errs[i] = 1'b0;

    // Reset during WAIT.
    issue(32'h04, 3'b001);
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    ecnt_m[0] = 0;
    ecnt_m[1] = 0;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rst_wait_no_rd_en%0d", i), rd_en[i], 0);
        check($sformatf("rst_wait_no_rvalid%0d", i), rv[i], 0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_wait_release_arready%0d", i), ar[i], 1);
      check($sformatf("rst_wait_release_rd_en%0d", i), rd_en[i], 0);
    end

    // Reset during RESP while the master is stalling.
    rready = 1'b0;
    issue(32'h10, 3'b001);
    @(negedge clk);
    arvalid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("rst_resp_pre_rvalid%0d", i), rv[i], 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    rready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_resp_release_arready%0d", i), ar[i], 1);
      check($sformatf("rst_resp_release_rvalid%0d", i), rv[i], 0);
    end

    // Clean read after reset.
    regs[0] = 32'h0BAD_F00D;
    errs[0] = 1'b0;
    issue(32'h00, 3'b001);
    collect(32'h00, 3'b001, 0, 1'b0, 0);

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      issue(32'h100, 3'b001);
      collect(32'h100, 3'b001, 0, 1'b0, 0);
    end
    for (int i = 0; i < 2; i++) check($sformatf("err_cnt_saturated%0d", i), ecnt_o[i], 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_slave_ctrl.md
Name: axi_lite_rd_slave_ctrl

Overview:
AXI4-Lite slave-side read controller that sits directly upstream of the read data channel stage.
- Accepts the AR handshake and decodes and checks the address.
- Issues a one-cycle read to the local register bank.
- Produces RVALID/RDATA/RRESP and holds them until RREADY.
- Supports one outstanding read at a time.
- Keeps a saturating error counter for status.

Parameters:
ADDR_W, 32, width of ARADDR
DATA_W, 32, width of RDATA and reg_rd_data
NUM_REGS, 16, number of 32-bit registers mapped from byte offset 0; valid offsets are 0 .. NUM_REGS*4-4
PROT_CHECK, 0, when 1, reads with ARPROT[0]==0 (unprivileged) receive SLVERR
ERRCNT_W, 8, width of err_cnt

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
ARVALID  in  1  read address valid from master
ARREADY  out  1  read address ready
ARADDR  in  ADDR_W  read byte address
ARPROT  in  3  protection type
RVALID  out  1  read data valid
RREADY  in  1  read data ready from master
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
reg_rd_en  out  1  one-cycle register read strobe
reg_rd_addr  out  $clog2(NUM_REGS)  word index (ARADDR[..:2])
reg_rd_data  in  DATA_W  register data, valid the cycle after reg_rd_en
reg_rd_err  in  1  register bank error, sampled with reg_rd_data
err_cnt  out  ERRCNT_W  count of non-OKAY responses, saturating
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock ACLK.
  - ARESETn is asynchronous assert, synchronous release.
  - While ARESETn=0: ARREADY=0, RVALID=0, RDATA=0, RRESP=00, reg_rd_en=0, reg_rd_addr=0, err_cnt=0, busy=0, state=IDLE.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - ARREADY=1; it rises on the first ACLK edge after reset release.
  - AR handshake (ARVALID&&ARREADY) at edge N:
    - Latch ARADDR and ARPROT.
    - ARREADY=0 from N.
    - Classify the request, in priority order:
      1. Offset >= NUM_REGS*4 -> DECERR.
      2. ARADDR[1:0]!=0 -> SLVERR.
      3. PROT_CHECK&&!ARPROT[0] -> SLVERR.
    - Error path: go to RESP with RDATA=0 and RRESP set per the classification; RVALID=1 after edge N.
    - Otherwise: go to REQ.
- REQ:
  - reg_rd_en=1 for exactly one cycle; reg_rd_addr = latched word index.
  - Go to WAIT.
- WAIT:
  - At the edge ending WAIT, capture RDATA=reg_rd_data and RRESP = reg_rd_err ? 10 : 00; set RVALID=1 and go to RESP.
- Latency, AR handshake edge to RVALID high:
  - 3 cycles for a register read.
  - 1 cycle for a decode/check error.
- RESP:
  - RVALID, RDATA and RRESP are held stable while RREADY=0, for an unbounded time.
  - R handshake (RVALID&&RREADY) at edge M: RVALID=0, RDATA=0, RRESP=00, ARREADY=1, go to IDLE.
  - Next AR handshake is possible at edge M+1 at the earliest; there is no AR/R overlap.
- ARVALID asserted while not in IDLE is ignored; ARREADY=0, so the master holds it.
- RREADY asserted before RVALID has no effect; it may be held high permanently.
- err_cnt:
  - Increments by 1 on each R handshake with RRESP!=00.
  - Saturates at all-ones with no wrap.
- Reset mid-operation (any state): immediate return to reset values; the pending transaction is dropped and not completed, and no reg_rd_en pulse follows.
- reg_rd_addr holds its last value when reg_rd_en=0.

Test Plan:
1. Reset, then ARADDR=0x08, ARVALID for 1 cycle, reg bank returns 0xDEADBEEF with err=0, RREADY=1 -> reg_rd_en pulses once with reg_rd_addr=2; RVALID high 3 cycles after the AR handshake with RDATA=0xDEADBEEF, RRESP=00; ARREADY=1 the cycle after the R handshake; err_cnt=0.
2. ARADDR=0x40 with NUM_REGS=16 -> no reg_rd_en; RVALID 1 cycle after the AR handshake with RRESP=11, RDATA=0; err_cnt=1. Then ARADDR=0x06 -> RRESP=10 (SLVERR).
3. Backpressure: RREADY=0 for 10 cycles after RVALID, while ARVALID is held with a new address -> RDATA/RRESP stable all 10 cycles; ARREADY=0 throughout; second AR accepted the cycle after the R handshake.
4. reg_rd_err=1 on a read of 0x0C with data 0x1234 -> RRESP=10, RDATA=0x1234; err_cnt increments.
5. PROT_CHECK=1: ARPROT=000 -> RRESP=10, no reg_rd_en. ARPROT=001 -> normal OKAY read.
6. ARESETn asserted in WAIT and in RESP -> RVALID/ARREADY drop to 0 immediately and no response completes. After release, ARREADY=1 on the next edge and a clean read to 0x00 returns OKAY. Separately, 260 forced DECERRs -> err_cnt=255.
